logic_op_pipe: RTL and testbench

Parametrised, registered successor to the single-bit `(a ^ b) | c` combinational block. It applies one of four selectable bitwise operations to WIDTH-bit operands and carries the result through a STAGES-deep valid/ready pipeline with full backpressure. It also keeps a wrap-around count of delivered results. It sits between operand producers and any consumer that may stall, such as a display or UART path in the lab top level.

---
 rtl/logic_op_pkg.sv | 33 +++
 rtl/logic_op_pipe_stage.sv | 32 +++
 rtl/logic_op_pipe.sv | 77 +++++++
 tb/tb_logic_op_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared mode encodings and the bitwise operation applied to each operand set.
// apply_op works on up to MAX_W bits; callers pass their real width to mask the result.
package logic_op_pkg;

    localparam logic [1:0] MODE_XOR_OR  = 2'b00;
    localparam logic [1:0] MODE_AND_OR  = 2'b01;
    localparam logic [1:0] MODE_OR_XOR  = 2'b10;
    localparam logic [1:0] MODE_NXOR_OR = 2'b11;

    // Widest operand the shared function supports.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] apply_op(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [MAX_W-1:0] c,
        input logic [1:0]       mode,
        input int unsigned      width
    );
        logic [MAX_W-1:0] r;
        logic [MAX_W-1:0] mask;
        case (mode)
            MODE_XOR_OR: r = (a ^ b) | c;
            MODE_AND_OR: r = (a & b) | c;
            MODE_OR_XOR: r = (a | b) ^ c;
            default:     r = ~((a ^ b) | c);
        endcase
        // The inverting mode sets bits above the caller's width; clear them.
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        return r & mask;
    endfunction

endpackage

// File: rtl/logic_op_pipe_stage.sv
// One pipeline slot: data register plus valid bit, loading from upstream when it advances.
// A slot advances when it is empty or when the slot downstream can take its contents.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_open,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic advance;

    assign advance = ~valid | down_open;

    // Data only loads with a valid item so idle slots keep their last contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (advance) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Selectable bitwise operation on WIDTH-bit operands, carried through a STAGES-deep
// valid/ready pipeline with full backpressure and a wrap-around delivered-result count.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [CNT_W-1:0] count
);

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
    // valid never waits on ready, and a producer holding valid must keep its data stable.

    logic [WIDTH-1:0] op_result;
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0] d [STAGES];

    assign op_result = WIDTH'(apply_op(MAX_W'(a), MAX_W'(b), MAX_W'(c), mode, WIDTH));

    // Stage 1 can advance whenever any slot is free or the tail is leaving this cycle.
    assign in_ready  = out_ready | ~(&v);
    assign out_valid = v[STAGES-1];
    assign x         = d[STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid_i;
        logic [WIDTH-1:0] up_data_i;
        logic             down_open_i;

        if (i == 0) begin : g_first
            assign up_valid_i = in_valid;
            assign up_data_i  = op_result;
        end else begin : g_chain
            assign up_valid_i = v[i-1];
            assign up_data_i  = d[i-1];
        end

        // Downstream is open if the output drains or some later slot has room.
        if (i == STAGES - 1) begin : g_tail
            assign down_open_i = out_ready;
        end else begin : g_inner
            assign down_open_i = out_ready | ~(&v[STAGES-1:i+1]);
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_valid  (up_valid_i),
            .up_data   (up_data_i),
            .down_open (down_open_i),
            .valid     (v[i]),
            .data      (d[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (out_valid && out_ready) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: scoreboard queue of expected results, occupancy model
// for in_ready, and a second instance with a 4-bit counter to observe wrap-around.
module tb_logic_op_pipe;

    localparam int W      = 8;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b, c;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic [7:0]   count;

    logic         in_ready_c4;
    logic         out_valid_c4;
    logic [W-1:0] x_c4;
    logic [3:0]   count_c4;

    int total = 0;
    int bad   = 0;
    int occ   = 0;
    int delivered = 0;
    logic last_in_hs;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sweep_tbl [4];

    always #5 clk = ~clk;

    logic_op_pipe #(.WIDTH(W), .STAGES(STAGES), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .x(x), .count(count)
    );

    logic_op_pipe #(.WIDTH(W), .STAGES(STAGES), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c4),
        .a(a), .b(b), .c(c), .mode(mode),
        .out_valid(out_valid_c4), .out_ready(out_ready), .x(x_c4), .count(count_c4)
    );

    function automatic logic [W-1:0] model_op(input logic [W-1:0] ma, mb, mc, input logic [1:0] mm);
        case (mm)
            2'd0:    return (ma ^ mb) | mc;
            2'd1:    return (ma & mb) | mc;
            2'd2:    return (ma | mb) ^ mc;
            default: return ~((ma ^ mb) | mc);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_ops();
        a    = W'($urandom_range(0, 255));
        b    = W'($urandom_range(0, 255));
        c    = W'($urandom_range(0, 255));
        mode = 2'($urandom_range(0, 3));
    endtask

    // One cycle: inputs are already driven at the negedge; sample, score, then advance.
    task automatic tick();
        logic exp_rdy;
        logic out_hs;
        #1;
        exp_rdy = out_ready || (occ < STAGES);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("count", {24'd0, count}, 32'(delivered % 256));
        chk("count_c4", {28'd0, count_c4}, 32'(delivered % 16));
        out_hs = out_valid && out_ready;
        if (out_hs) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL x_unexpected: observed=%0h expected=none", x);
            end else begin
                chk("x", {24'd0, x}, {24'd0, exp_q.pop_front()});
            end
            delivered++;
        end
        last_in_hs = in_valid && exp_rdy;
        if (last_in_hs) exp_q.push_back(model_op(a, b, c, mode));
        occ = occ + int'(last_in_hs) - int'(out_hs);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        sweep_tbl[0] = 8'hB5;
        sweep_tbl[1] = 8'h1B;
        sweep_tbl[2] = 8'hBE;
        sweep_tbl[3] = 8'h4A;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; mode = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_x", {24'd0, x}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single operation and its latency.
        a = 8'hF0; b = 8'h3C; c = 8'h01; mode = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_cycle1_ov", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_cycle2_ov", {31'd0, out_valid}, 32'd1);
        chk("single_x", {24'd0, x}, 32'h0000_00CD);
        tick();
        chk("single_count", {24'd0, count}, 32'd1);

        // Mode sweep, back-to-back.
        a = 8'hAA; b = 8'h0F; c = 8'h11;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            in_valid = 1'b1;
            if (m >= 2) begin
                chk("sweep_ov", {31'd0, out_valid}, 32'd1);
                chk("sweep_x", {24'd0, x}, {24'd0, sweep_tbl[m-2]});
            end
            tick();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            chk("sweep_tail_ov", {31'd0, out_valid}, 32'd1);
            chk("sweep_tail_x", {24'd0, x}, {24'd0, sweep_tbl[2+j]});
            tick();
        end
        chk("sweep_idle_ov", {31'd0, out_valid}, 32'd0);

        // Backpressure: four items offered while the consumer stalls.
        begin
            int sent;
            sent = 0;
            out_ready = 1'b0;
            new_ops();
            in_valid = 1'b1;
            for (int n = 0; n < 4; n++) begin
                tick();
                if (last_in_hs) begin
                    sent++;
                    new_ops();
                end
            end
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_ov", {31'd0, out_valid}, 32'd1);
            chk("bp_x_head", {24'd0, x}, {24'd0, exp_q[0]});
            tick();
            tick();
            chk("bp_x_held", {24'd0, x}, {24'd0, exp_q[0]});
            out_ready = 1'b1;
            for (int n = 0; n < 10 && sent < 4; n++) begin
                tick();
                if (last_in_hs) begin
                    sent++;
                    new_ops();
                end
            end
            drain();
        end

        // Full pipe with the consumer toggling; accepts only as results leave.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_ops();
        for (int n = 0; n < 10 && occ < STAGES; n++) begin
            tick();
            if (last_in_hs) new_ops();
        end
        for (int n = 0; n < 12; n++) begin
            out_ready = (n % 2 == 0);
            chk("tog_ov", {31'd0, out_valid}, 32'd1);
            tick();
            if (last_in_hs) new_ops();
        end
        drain();
        chk("cnt_17", {24'd0, count}, 32'd17);
        chk("cnt4_wrap", {28'd0, count_c4}, 32'd1);

        // Asynchronous reset between edges while results are in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        new_ops();
        tick();
        new_ops();
        tick();
        chk("pre_rst_ov", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ov", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {24'd0, count}, 32'd0);
        chk("arst_count_c4", {28'd0, count_c4}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        occ = 0;
        delivered = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        new_ops();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("post_rst_lat2", {31'd0, out_valid}, 32'd1);
        drain();
        chk("post_rst_count", {24'd0, count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
